demux_ff: RTL and testbench

DEMUX_FF -- requirements
Module: demux_ff

---
 rtl/demux_ff_pkg.sv | 16 +
 rtl/demux_ff_lane.sv | 56 +++++
 rtl/demux_ff.sv | 89 ++++++++
 tb/tb_demux_ff.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_ff_pkg.sv
// Shared constants and helpers for the 1-to-4 registered demultiplexer.
// Lane count, select width and counter width live here so lane and top agree.
package demux_ff_pkg;

   localparam int NLANES = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Counters stick at their maximum instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/demux_ff_lane.sv
// One output lane: data register, valid bit and saturating delivered-word counter.
// A drain and a load on the same edge keep the lane full with the new word.
module demux_ff_lane
   import demux_ff_pkg::*;
#(
   parameter int W = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [W-1:0]     load_data_i,
   input  logic             out_ready_i,
   output logic [W-1:0]     out_data_o,
   output logic             out_valid_o,
   output logic [CNT_W-1:0] xfer_cnt_o
);

   logic [W-1:0]     data_q,  data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             drain;

   assign drain = valid_q & out_ready_i;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (drain) begin
         valid_d = 1'b0;
         cnt_d   = sat_inc(cnt_q);
      end
      // Load is applied after drain so a same-cycle refill leaves no bubble.
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = load_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;
   assign xfer_cnt_o  = cnt_q;

endmodule

// File: rtl/demux_ff.sv
// Registered 1-to-4 demultiplexer with per-lane enables, handshakes and counters.
// Words sent to a disabled lane are accepted and discarded, raising a sticky error.
module demux_ff
   import demux_ff_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [W-1:0]            in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NLANES-1:0]       lane_en,
   output logic [NLANES*W-1:0]     out_data,
   output logic [NLANES-1:0]       out_valid,
   input  logic [NLANES-1:0]       out_ready,
   output logic [NLANES*CNT_W-1:0] xfer_cnt,
   output logic [CNT_W-1:0]        drop_cnt,
   input  logic                    err_clr,
   output logic                    err_drop
);

   logic              sel_en;
   logic              sel_busy;
   logic              accept;
   logic              drop;
   logic [NLANES-1:0] lane_load;

   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              err_q,  err_d;

   // A disabled destination always accepts (the word is dropped); an enabled
   // one accepts when empty or when its consumer drains it this cycle.
   assign sel_en   = lane_en[in_sel];
   assign sel_busy = out_valid[in_sel] & ~out_ready[in_sel];
   assign in_ready = ~rst & (~sel_en | ~sel_busy);
   assign accept   = in_valid & in_ready;
   assign drop     = accept & ~sel_en;

   always_comb begin
      lane_load = '0;
      for (int k = 0; k < NLANES; k++) begin
         lane_load[k] = accept & sel_en & (in_sel == SEL_W'(k));
      end
   end

   genvar g;
   for (g = 0; g < NLANES; g++) begin : g_lane
      demux_ff_lane #(
         .W (W)
      ) u_lane (
         .clk_i       (clk),
         .rst_i       (rst),
         .load_i      (lane_load[g]),
         .load_data_i (in_data),
         .out_ready_i (out_ready[g]),
         .out_data_o  (out_data[g*W +: W]),
         .out_valid_o (out_valid[g]),
         .xfer_cnt_o  (xfer_cnt[g*CNT_W +: CNT_W])
      );
   end

   // A discard in the same cycle as err_clr wins.
   always_comb begin
      drop_d = drop_q;
      err_d  = err_q;
      if (drop) begin
         drop_d = sat_inc(drop_q);
         err_d  = 1'b1;
      end else if (err_clr) begin
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
         err_q  <= 1'b0;
      end else begin
         drop_q <= drop_d;
         err_q  <= err_d;
      end
   end

   assign drop_cnt = drop_q;
   assign err_drop = err_q;

endmodule

// File: tb/tb_demux_ff.sv
// Bench for demux_ff (W=8): directed vector table, hand-written corner sequences,
// then randomized traffic compared against a lane-level behavioural model.
module tb_demux_ff;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  lane_en;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] xfer_cnt;
   logic [7:0]  drop_cnt;
   logic        err_clr;
   logic        err_drop;

   demux_ff #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .lane_en   (lane_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt),
      .drop_cnt  (drop_cnt),
      .err_clr   (err_clr),
      .err_drop  (err_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: each lane is a one-word mailbox with a delivery count.
   bit         m_vld  [4];
   logic [7:0] m_data [4];
   int         m_xfer [4];
   int         m_drop;
   bit         m_err;

   function automatic bit m_ready();
      if (rst) return 1'b0;
      if (!lane_en[in_sel]) return 1'b1;
      return !m_vld[in_sel] || out_ready[in_sel];
   endfunction

   task automatic model_edge();
      bit acc;
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_vld[k] = 0; m_data[k] = 8'h00; m_xfer[k] = 0;
         end
         m_drop = 0;
         m_err  = 0;
         return;
      end
      acc = in_valid && m_ready();
      for (int k = 0; k < 4; k++) begin
         if (m_vld[k] && out_ready[k]) begin
            m_vld[k] = 0;
            if (m_xfer[k] < 255) m_xfer[k] = m_xfer[k] + 1;
         end
      end
      if (acc && lane_en[in_sel]) begin
         m_vld[int'(in_sel)]  = 1;
         m_data[int'(in_sel)] = in_data;
      end
      if (acc && !lane_en[in_sel]) begin
         if (m_drop < 255) m_drop = m_drop + 1;
         m_err = 1;
      end else if (err_clr) begin
         m_err = 0;
      end
   endtask

   logic last_rdy;

   task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] en, input logic [3:0] ordy, input logic clr);
      logic [3:0]  e_ov;
      logic [31:0] e_od, e_xf;
      rst = r; in_valid = v; in_sel = s; in_data = d;
      lane_en = en; out_ready = ordy; err_clr = clr;
      #1;
      last_rdy = in_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 4; k++) begin
         e_ov[k]         = m_vld[k];
         e_od[k*8 +: 8]  = m_data[k];
         e_xf[k*8 +: 8]  = 8'(m_xfer[k]);
      end
      check("out_valid", {28'd0, out_valid}, {28'd0, e_ov});
      check("out_data", out_data, e_od);
      check("xfer_cnt", xfer_cnt, e_xf);
      check("drop_cnt", {24'd0, drop_cnt}, {24'd0, 8'(m_drop)});
      check("err_drop", {31'd0, err_drop}, {31'd0, m_err});
   endtask

   typedef struct {
      logic        r, v;
      logic [1:0]  s;
      logic [7:0]  d;
      logic [3:0]  en, ordy;
      logic        clr;
      logic        exp_rdy;
      logic [3:0]  exp_ov;
      logic [31:0] exp_od;
      logic [7:0]  exp_drop;
      logic        exp_err;
   } vec_t;

   vec_t tbl[18];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
      lane_en = 4'hF; out_ready = 4'hF; err_clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_vld[k] = 0; m_data[k] = 8'h00; m_xfer[k] = 0;
      end
      m_drop = 0; m_err = 0;

      //            r     v     s     d      en     ordy   clr   rdy   ov       od             drop  err
      tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 8'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0100, 32'h00A5_0000, 8'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h00A5_0000, 8'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'hF, 4'hD, 1'b0, 1'b1, 4'b0010, 32'h00A5_1100, 8'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'hF, 4'hD, 1'b0, 1'b0, 4'b0010, 32'h00A5_1100, 8'd0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, 32'h00A5_2200, 8'd0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h00A5_2200, 8'd0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h31, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, 32'h00A5_3100, 8'd0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 2'd1, 8'h32, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, 32'h00A5_3200, 8'd0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, 32'h00A5_3300, 8'd0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h00A5_3300, 8'd0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 2'd0, 8'h77, 4'hE, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h00A5_3300, 8'd1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hE, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h00A5_3300, 8'd1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 2'd0, 8'h78, 4'hE, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h00A5_3300, 8'd2, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 2'd0, 8'h79, 4'hE, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h00A5_3300, 8'd3, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 2'd3, 8'hC3, 4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 32'hC3A5_3300, 8'd3, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'h7, 4'h0, 1'b0, 1'b1, 4'b1000, 32'hC3A5_3300, 8'd3, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'h7, 4'h8, 1'b0, 1'b1, 4'b0000, 32'hC3A5_3300, 8'd3, 1'b1};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].en, tbl[i].ordy, tbl[i].clr);
         check($sformatf("tbl%0d.in_ready", i), {31'd0, last_rdy}, {31'd0, tbl[i].exp_rdy});
         check($sformatf("tbl%0d.out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].exp_ov});
         check($sformatf("tbl%0d.out_data", i), out_data, tbl[i].exp_od);
         check($sformatf("tbl%0d.drop_cnt", i), {24'd0, drop_cnt}, {24'd0, tbl[i].exp_drop});
         check($sformatf("tbl%0d.err_drop", i), {31'd0, err_drop}, {31'd0, tbl[i].exp_err});
      end
      check("xfer_lane2_once", {24'd0, xfer_cnt[23:16]}, 32'd1);
      check("xfer_lane1_five", {24'd0, xfer_cnt[15:8]}, 32'd5);

      // 300 back-to-back deliveries on lane 3 saturate its counter.
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 2'd3, 8'(i), 4'hF, 4'hF, 1'b0);
      step(1'b0, 1'b0, 2'd3, 8'h00, 4'hF, 4'hF, 1'b0);
      check("xfer_lane3_sat", {24'd0, xfer_cnt[31:24]}, 32'd255);

      // 260 discards saturate the drop counter.
      for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 2'(i), 8'(i), 4'h0, 4'hF, 1'b0);
      check("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
      check("err_after_drops", {31'd0, err_drop}, 32'd1);

      // Reset while lane 0 holds an undelivered word.
      step(1'b0, 1'b1, 2'd0, 8'h5A, 4'hF, 4'h0, 1'b0);
      check("lane0_full", {31'd0, out_valid[0]}, 32'd1);
      step(1'b1, 1'b1, 2'd1, 8'h66, 4'hF, 4'h0, 1'b0);
      check("rst_in_ready", {31'd0, last_rdy}, 32'd0);
      check("rst_out_valid", {28'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_xfer_cnt", xfer_cnt, 32'd0);
      check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      check("rst_err_drop", {31'd0, err_drop}, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 99) == 0),
              1'($urandom),
              2'($urandom),
              8'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
              4'($urandom),
              ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
